instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  Fetch stage plus IF/ID pipeline register; directly feeds the decode stage.
//  Holds the PC and requests instructions from instruction memory.
//  Applies branch/jump redirects from EX and stall/flush controls from the hazard unit.
//  Presents InstrD/PCD/PCPlus4D/ValidD to decode; invalid slots carry a NOP.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded at reset
//  NOP_INSTR 32'h0000_0013  encoding driven on InstrD for bubbles (addi x0,x0,0)
// PORTS
//  clk          in   1   clock, rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  imem_req     out  1   fetch request; address on imem_addr
//  imem_addr    out  32  PC of the requested instruction (word aligned)
//  imem_rdata   in   32  instruction word, valid in the same cycle as imem_ack
//  imem_ack     in   1   memory returned imem_rdata for imem_addr this cycle
//  StallD       in   1   hazard unit: hold PC and the IF/ID register
//  FlushD       in   1   hazard unit: replace the IF/ID contents with a bubble
//  PCSrcE       in   1   redirect taken (branch taken or jal) from EX
//  PCTargetE    in   32  redirect target
//  InstrD       out  32  instruction to decode
//  PCD          out  32  PC of InstrD
//  PCPlus4D     out  32  PCD + 4
//  ValidD       out  1   InstrD is a real fetched instruction
//  MisalignErr  out  1   sticky: a redirect target had bits [1:0] != 0
// BEHAVIOUR
//  Reset (async, rst_n=0): PC=RESET_PC, state=BOOT, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0,
//   ValidD=0, MisalignErr=0, imem_req=0. Outputs take these values immediately on rst_n low,
//   including mid-operation.
//  FSM: BOOT -> RUN on the first clock edge after rst_n rises. RUN persists until reset.
//   In BOOT: imem_req=0, PC held, IF/ID held at its bubble value.
//  RUN: imem_req=1 and imem_addr=PC every cycle (combinational from PC).
//  Fetch completes when imem_ack=1 and StallD=0.
//  PC update each RUN edge, first match wins:
//   1. PCSrcE=1        -> PC <= {PCTargetE[31:2],2'b00}; if PCTargetE[1:0]!=0, set MisalignErr.
//   2. StallD=1        -> PC held.
//   3. imem_ack=1      -> PC <= PC+4 (32-bit, wraps 0xFFFF_FFFC -> 0x0000_0000).
//   4. imem_ack=0      -> PC held (request stays asserted at the same address).
//  IF/ID update each RUN edge, first match wins:
//   1. FlushD=1 or PCSrcE=1 -> bubble: InstrD=NOP_INSTR, ValidD=0; PCD/PCPlus4D hold.
//   2. StallD=1             -> all IF/ID outputs hold.
//   3. imem_ack=1           -> InstrD<=imem_rdata, PCD<=PC, PCPlus4D<=PC+4, ValidD<=1.
//   4. imem_ack=0           -> bubble (same as rule 1).
//  Redirect has priority over stall for the PC, so a taken branch is never lost.
//  Flush has priority over stall for IF/ID.
//  Discard rules:
//   - ack with StallD=1: the word is discarded and the same PC is refetched next cycle.
//   - ack with PCSrcE=1: the word is discarded.
//  Latency:
//   - ack -> decode: 1 cycle (word acked at edge n appears on InstrD after edge n).
//   - redirect -> target address: 1 cycle (target on imem_addr the cycle after PCSrcE).
//  MisalignErr clears only on reset.
//  No X propagation: imem_rdata is sampled only when imem_ack=1.
// TESTING
//  T1 reset/boot:
//   rst_n low 3 cycles, then high -> imem_req=0 for 1 cycle, then 1 with imem_addr=0x0.
//   ValidD=0 and InstrD=0x00000013 throughout.
//  T2 streaming: ack=1 every cycle with rdata=addr^0xA5A5_0000 ->
//   InstrD sequence 0xA5A50000, 0xA5A50004, ...; PCD=0,4,8; PCPlus4D=PCD+4; ValidD=1.
//  T3 stall: StallD=1 for 2 cycles while ack=1 at PC=0x8 ->
//   IF/ID outputs and PC frozen; after release imem_addr=0x8 is refetched; no instruction
//   lost or duplicated.
//  T4 redirect:
//   PCSrcE=1, PCTargetE=0x100 with StallD=1 and ack=1 -> next imem_addr=0x100, ValidD=0 next cycle.
//   PCTargetE=0x102 -> imem_addr=0x100 and MisalignErr=1 (sticky).
//  T5 memory wait: ack=0 for 3 cycles at PC=0x20 ->
//   imem_addr stays 0x20, ValidD=0 for 3 cycles; ack=1 -> InstrD=rdata, PCD=0x20.
//  T6 edge cases:
//   - RESET_PC=0xFFFFFFFC, ack=1 -> PC wraps to 0x0.
//   - rst_n low mid-stream -> all outputs return to reset values asynchronously.
//   - FlushD with StallD together -> bubble.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage with PC register and IF/ID pipeline register feeding decode.
// Redirects beat stalls for the PC; flushes beat stalls for the IF/ID slot.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        MisalignErr
);

  typedef enum logic [0:0] {StBoot, StRun} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pcd_d      = pcd_q;
    pcp4_d     = pcp4_q;
    valid_d    = valid_q;
    misalign_d = misalign_q;

    unique case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (PCSrcE) begin
          pc_d = {PCTargetE[31:2], 2'b00};
          if (PCTargetE[1:0] != 2'b00) misalign_d = 1'b1;
        end else if (!StallD && imem_ack) begin
          pc_d = pc_plus4;
        end

        // imem_rdata is only looked at on the load path, which requires imem_ack.
        if (FlushD || PCSrcE) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end else if (StallD) begin
          instr_d = instr_q;
        end else if (imem_ack) begin
          instr_d = imem_rdata;
          pcd_d   = pc_q;
          pcp4_d  = pc_plus4;
          valid_d = 1'b1;
        end else begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StBoot;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      pcd_q      <= 32'd0;
      pcp4_q     <= 32'd0;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pcd_q      <= pcd_d;
      pcp4_q     <= pcp4_d;
      valid_q    <= valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_req    = (state_q == StRun);
  assign imem_addr   = pc_q;
  assign InstrD      = instr_q;
  assign PCD         = pcd_q;
  assign PCPlus4D    = pcp4_q;
  assign ValidD      = valid_q;
  assign MisalignErr = misalign_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: two instances (reset PC 0 and 0xFFFFFFFC) share stimulus and
// are checked every cycle against a transaction-level model of the fetch stage.
module tb_instruction_fetch;

  localparam logic [31:0] Nop = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_ack, StallD, FlushD, PCSrcE;
  logic [31:0] imem_rdata, PCTargetE;

  logic        req   [2];
  logic [31:0] addr  [2];
  logic [31:0] instr [2];
  logic [31:0] pcd   [2];
  logic [31:0] pcp4  [2];
  logic        valid [2];
  logic        mis   [2];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(32'h0000_0000), .NOP_INSTR(Nop)) dut0 (
    .clk(clk), .rst_n(rst_n), .imem_req(req[0]), .imem_addr(addr[0]),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .InstrD(instr[0]), .PCD(pcd[0]),
    .PCPlus4D(pcp4[0]), .ValidD(valid[0]), .MisalignErr(mis[0])
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(Nop)) dut1 (
    .clk(clk), .rst_n(rst_n), .imem_req(req[1]), .imem_addr(addr[1]),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .InstrD(instr[1]), .PCD(pcd[1]),
    .PCPlus4D(pcp4[1]), .ValidD(valid[1]), .MisalignErr(mis[1])
  );

  // Model: the fetch stage as "what address is being asked for" and "what decode sees".
  typedef struct {
    bit          running;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] pcp4;
    bit          valid;
    bit          mis;
  } mdl_t;

  mdl_t m [2];
  logic [31:0] reset_pc [2];

  function automatic mdl_t reset_model(logic [31:0] rpc);
    mdl_t r;
    r.running = 0; r.pc = rpc; r.instr = Nop; r.pcd = 0; r.pcp4 = 0; r.valid = 0; r.mis = 0;
    return r;
  endfunction

  function automatic mdl_t next_model(mdl_t s, bit ack, logic [31:0] word, bit stall,
                                      bit flush, bit redirect, logic [31:0] target);
    mdl_t n = s;
    bit fetched;
    if (!s.running) begin
      n.running = 1;
      return n;
    end
    fetched = ack && !stall && !redirect;
    if (redirect) begin
      n.pc = target - (target % 4);
      if (target % 4 != 0) n.mis = 1;
    end else if (fetched) begin
      n.pc = s.pc + 4;
    end
    if (flush || redirect || (!stall && !ack)) begin
      n.instr = Nop;
      n.valid = 0;
    end else if (fetched) begin
      n.instr = word;
      n.pcd   = s.pc;
      n.pcp4  = s.pc + 4;
      n.valid = 1;
    end
    return n;
  endfunction

  task automatic chk(string tag, int i, logic [31:0] got, logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s[dut%0d] @%0t: got %h expected %h", tag, i, $time, got, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk("imem_req", i, {31'd0, req[i]}, {31'd0, m[i].running});
      if (m[i].running) chk("imem_addr", i, addr[i], m[i].pc);
      chk("InstrD", i, instr[i], m[i].instr);
      chk("PCD", i, pcd[i], m[i].pcd);
      chk("PCPlus4D", i, pcp4[i], m[i].pcp4);
      chk("ValidD", i, {31'd0, valid[i]}, {31'd0, m[i].valid});
      chk("MisalignErr", i, {31'd0, mis[i]}, {31'd0, m[i].mis});
    end
  endtask

  // One clock: drive inputs, advance the model, check 1ns after the rising edge.
  task automatic step(bit ack, bit stall, bit flush, bit redirect, logic [31:0] target);
    logic [31:0] word;
    word       = m[0].pc ^ 32'hA5A5_0000;
    imem_ack   = ack;
    imem_rdata = ack ? word : 32'hDEAD_BEEF;
    StallD     = stall;
    FlushD     = flush;
    PCSrcE     = redirect;
    PCTargetE  = target;
    for (int i = 0; i < 2; i++) begin
      if (rst_n) m[i] = next_model(m[i], ack, word, stall, flush, redirect, target);
      else m[i] = reset_model(reset_pc[i]);
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) m[i] = reset_model(reset_pc[i]);
    check_all();
    step(1, 0, 0, 0, 0);
    rst_n = 1'b1;
    check_all();
  endtask

  initial begin
    reset_pc[0] = 32'h0000_0000;
    reset_pc[1] = 32'hFFFF_FFFC;
    for (int i = 0; i < 2; i++) m[i] = reset_model(reset_pc[i]);
    rst_n = 1'b0;
    imem_ack = 0; StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = 0; imem_rdata = 0;

    // Reset held 3 cycles, then boot cycle with no request.
    repeat (3) step(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    check_all();
    step(0, 0, 0, 0, 0);

    // Streaming; dut1 wraps from 0xFFFFFFFC to 0 on its first fetch.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Stall two cycles with ack at PC 0x8, then refetch 0x8.
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Redirect beats stall; then a misaligned target.
    step(1, 1, 0, 1, 32'h0000_0100);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 32'h0000_0102);
    step(1, 0, 0, 0, 0);

    // Memory wait at 0x20.
    step(1, 0, 0, 1, 32'h0000_0020);
    repeat (3) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Flush together with stall gives a bubble.
    step(1, 1, 1, 0, 0);
    step(1, 0, 0, 0, 0);

    // Asynchronous reset mid-stream.
    async_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0,
           $urandom_range(0, 7) == 0, $urandom);
      if (n == 150) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
